// File: rtl/fixed_norm_alu_seq_if.sv
// Request/result handshake bundle for fixed_norm_alu_seq.
// master drives requests and accepts results; slave is the ALU.
interface fixed_norm_alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_value;
  logic             out_ovf;
  logic             out_dbz;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, out_value, out_ovf, out_dbz
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, out_value, out_ovf, out_dbz
  );
endinterface

// File: rtl/fixed_norm_alu_seq.sv
// Handshaked FixedNorm signed fixed-point ALU with an iterative restoring divider.
// Define FIXED_NORM_SAT_EN to clamp overflowed results instead of wrapping them.
//
// state | meaning
// IDLE  | no result held, ready for a request
// CALC  | dividing, one quotient bit per cycle
// DONE  | result held on out_value until consumed
module fixed_norm_alu_seq #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input logic                 clk,
  input logic                 reset,
  fixed_norm_alu_seq_if.slave bus
);
  localparam int NW = WIDTH + FRAC;
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(NW + 1);
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_MIN = 3'd4;
  localparam logic [2:0] OP_MAX = 3'd5;
  localparam logic [2:0] OP_ABS = 3'd6;
  localparam logic [2:0] OP_NEG = 3'd7;

`ifdef FIXED_NORM_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [NW-1:0]    num_q, num_d;
  logic [NW-1:0]    quot_q, quot_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             qneg_q, qneg_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             ovf_q, ovf_d;
  logic             dbz_q, dbz_d;

  function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] val,
                                             input logic ovf, input logic neg);
    return (SAT_EN && ovf) ? (neg ? MAX_NEG : MAX_POS) : val;
  endfunction

  // Unsigned magnitude to signed result: range check, truncate, re-apply sign.
  function automatic logic [WIDTH:0] finish_mag(input logic [PW-1:0] mag, input logic neg);
    logic             ovf;
    logic [WIDTH-1:0] low;
    ovf = |mag[PW-1:WIDTH-1];
    low = neg ? (~mag[WIDTH-1:0] + 1'b1) : mag[WIDTH-1:0];
    return {ovf, clamp(low, ovf, neg)};
  endfunction

  logic             a_neg, b_neg, a_min, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag, neg_a, sum, diff;
  logic [PW-1:0]    prod_sh;
  logic [WIDTH-1:0] res_val;
  logic             res_ovf, res_dbz;
  logic             in_ready, accept, go_calc;

  assign a_neg   = bus.a[WIDTH-1];
  assign b_neg   = bus.b[WIDTH-1];
  assign neg_a   = ~bus.a + 1'b1;
  assign a_mag   = a_neg ? neg_a : bus.a;
  assign b_mag   = b_neg ? (~bus.b + 1'b1) : bus.b;
  assign a_min   = a_neg & ~|bus.a[WIDTH-2:0];
  assign b_zero  = ~|bus.b;
  assign sum     = bus.a + bus.b;
  assign diff    = bus.a - bus.b;
  assign prod_sh = ({{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag}) >> FRAC;

  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign go_calc  = (bus.op == OP_DIV) && !b_zero;

  always_comb begin
    res_val = '0;
    res_ovf = 1'b0;
    res_dbz = 1'b0;
    case (bus.op)
      OP_ADD: begin
        res_ovf = (a_neg == b_neg) && (sum[WIDTH-1] != a_neg);
        res_val = clamp(sum, res_ovf, a_neg);
      end
      OP_SUB: begin
        res_ovf = (a_neg != b_neg) && (diff[WIDTH-1] != a_neg);
        res_val = clamp(diff, res_ovf, a_neg);
      end
      OP_MUL: {res_ovf, res_val} = finish_mag(prod_sh, a_neg ^ b_neg);
      OP_DIV: begin
        res_val = MAX_POS;
        res_dbz = b_zero;
      end
      OP_MIN: res_val = ($signed(bus.b) < $signed(bus.a)) ? bus.b : bus.a;
      OP_MAX: res_val = ($signed(bus.b) > $signed(bus.a)) ? bus.b : bus.a;
      OP_ABS: begin
        res_ovf = a_min;
        res_val = clamp(a_mag, a_min, 1'b0);
      end
      OP_NEG: begin
        res_ovf = a_min;
        res_val = clamp(neg_a, a_min, ~a_neg);
      end
      default: ;
    endcase
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  logic [WIDTH:0]   rem_sh, rem_sub;
  logic             q_bit;
  logic [NW-1:0]    quot_nx;
  logic [WIDTH:0]   div_fin;

  assign rem_sh  = {rem_q, num_q[NW-1]};
  assign rem_sub = rem_sh - {1'b0, div_q};
  assign q_bit   = ~rem_sub[WIDTH];
  assign quot_nx = {quot_q[NW-2:0], q_bit};
  assign div_fin = finish_mag({{(PW-NW){1'b0}}, quot_nx}, qneg_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    num_d   = num_q;
    quot_d  = quot_q;
    div_d   = div_q;
    qneg_d  = qneg_q;
    value_d = value_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;

    case (state_q)
      CALC: begin
        rem_d  = q_bit ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        num_d  = {num_q[NW-2:0], 1'b0};
        quot_d = quot_nx;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          value_d = div_fin[WIDTH-1:0];
          ovf_d   = div_fin[WIDTH];
          dbz_d   = 1'b0;
        end
      end
      DONE: if (bus.out_ready) state_d = IDLE;
      default: ;
    endcase

    // Accept is only possible from IDLE or from DONE while the result is consumed.
    if (accept) begin
      if (go_calc) begin
        state_d = CALC;
        cnt_d   = CW'(NW);
        rem_d   = '0;
        num_d   = {a_mag, {FRAC{1'b0}}};
        quot_d  = '0;
        div_d   = b_mag;
        qneg_d  = a_neg ^ b_neg;
      end else begin
        state_d = DONE;
        value_d = res_val;
        ovf_d   = res_ovf;
        dbz_d   = res_dbz;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      num_q   <= '0;
      quot_q  <= '0;
      div_q   <= '0;
      qneg_q  <= 1'b0;
      value_q <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      num_q   <= num_d;
      quot_q  <= quot_d;
      div_q   <= div_d;
      qneg_q  <= qneg_d;
      value_q <= value_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_value = value_q;
  assign bus.out_ovf   = ovf_q;
  assign bus.out_dbz   = dbz_q;
endmodule

// File: tb/tb_fixed_norm_alu_seq.sv
// Self-checking bench for fixed_norm_alu_seq: vector table, latency/backpressure/reset
// sequences and random operations, all checked through an expected-result queue.
module tb_fixed_norm_alu_seq;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, MUL = 3'd2, DIV = 3'd3;
  localparam logic [2:0] MIN = 3'd4, MAX = 3'd5, ABS = 3'd6, NEG = 3'd7;
  localparam longint LMAX = 64'sd2147483647;
  localparam longint LMIN = -64'sd2147483648;

`ifdef FIXED_NORM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [31:0] v;
    logic        ovf;
    logic        dbz;
  } res_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] v;
    logic        ovf;
    logic        dbz;
  } vec_t;

  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  fixed_norm_alu_seq_if #(.WIDTH(32)) bus ();

  fixed_norm_alu_seq #(.WIDTH(32), .FRAC(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int   checks = 0;
  int   failures = 0;
  res_t sb_q[$];
  res_t pend;
  vec_t tv[$];

  function automatic logic [31:0] ov(input logic [31:0] wrap, input logic [31:0] sat);
    return SAT ? sat : wrap;
  endfunction

  function automatic res_t mk(input logic [31:0] v, input logic ovf, input logic dbz);
    res_t r;
    r.v = v; r.ovf = ovf; r.dbz = dbz;
    return r;
  endfunction

  function automatic vec_t mkv(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] v, input logic ovf, input logic dbz);
    vec_t t;
    t.op = op; t.a = a; t.b = b; t.v = v; t.ovf = ovf; t.dbz = dbz;
    return t;
  endfunction

  // Reference: exact 64-bit integer arithmetic, then range check and truncation.
  function automatic res_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    res_t   r;
    longint sa, sb, ma, mb, ex, mag;
    bit     neg, magmode;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    ex = 0; mag = 0; magmode = 1'b0;
    neg = (sa < 0) != (sb < 0);
    r.dbz = 1'b0;
    case (op)
      ADD: ex = sa + sb;
      SUB: ex = sa - sb;
      MUL: begin mag = (ma * mb) >> 16; magmode = 1'b1; end
      DIV: begin
        if (sb == 0) return mk(32'h7FFFFFFF, 1'b0, 1'b1);
        mag = (ma << 16) / mb;
        magmode = 1'b1;
      end
      MIN: ex = (sb < sa) ? sb : sa;
      MAX: ex = (sb > sa) ? sb : sa;
      ABS: ex = ma;
      default: ex = -sa;
    endcase
    if (magmode) begin
      ex = neg ? -mag : mag;
      r.ovf = (mag > LMAX);
    end else begin
      neg = (ex < 0);
      r.ovf = (ex > LMAX) || (ex < LMIN);
    end
    r.v = 32'(ex);
    if (SAT && r.ovf) r.v = neg ? 32'h80000001 : 32'h7FFFFFFF;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step(output bit acc);
    res_t r;
    #1;
    acc = bus.in_valid && bus.in_ready;
    if (bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual=%h required=no_output", bus.out_value);
      end else begin
        r = sb_q.pop_front();
        chk("sb_value", bus.out_value, r.v);
        chk("sb_ovf", bus.out_ovf, r.ovf);
        chk("sb_dbz", bus.out_dbz, r.dbz);
      end
    end
    if (acc) sb_q.push_back(pend);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input res_t e);
    bit acc;
    int n;
    bus.in_valid = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    pend = e;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      step(acc);
      n++;
      if (!acc) bus.out_ready = 1'b1;
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout op=%0d cycles=%0d required=accepted", op, n);
    end
  endtask

  task automatic drain();
    bit acc;
    int n = 0;
    bus.out_ready = 1'b1;
    while (sb_q.size() != 0 && n < 300) begin
      step(acc);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout pending=%0d required=0", sb_q.size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog checks=%0d required=finish", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    int k, seen;
    bit rdy_hi;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    tv.push_back(mkv(ADD, 32'h00010000, 32'h00020000, 32'h00030000, 1'b0, 1'b0));
    tv.push_back(mkv(ADD, 32'h7FFF0000, 32'h00020000, ov(32'h80010000, 32'h7FFFFFFF), 1'b1, 1'b0));
    tv.push_back(mkv(SUB, 32'h80000000, 32'h00010000, ov(32'h7FFF0000, 32'h80000001), 1'b1, 1'b0));
    tv.push_back(mkv(SUB, 32'h00010000, 32'h00030000, 32'hFFFE0000, 1'b0, 1'b0));
    tv.push_back(mkv(MUL, 32'hFFFE8000, 32'h00020000, 32'hFFFD0000, 1'b0, 1'b0));
    tv.push_back(mkv(MUL, 32'h00008000, 32'h00008000, 32'h00004000, 1'b0, 1'b0));
    tv.push_back(mkv(MUL, 32'h7FFF0000, 32'h00020000, ov(32'hFFFE0000, 32'h7FFFFFFF), 1'b1, 1'b0));
    tv.push_back(mkv(MUL, 32'hFFFFFFFF, 32'h00008000, 32'h00000000, 1'b0, 1'b0));
    tv.push_back(mkv(MUL, 32'h80000000, 32'hFFFF0000, ov(32'h80000000, 32'h7FFFFFFF), 1'b1, 1'b0));
    tv.push_back(mkv(DIV, 32'h00010000, 32'h00030000, 32'h00005555, 1'b0, 1'b0));
    tv.push_back(mkv(DIV, 32'hFFFF0000, 32'h00000000, 32'h7FFFFFFF, 1'b0, 1'b1));
    tv.push_back(mkv(DIV, 32'h00030000, 32'hFFFE0000, 32'hFFFE8000, 1'b0, 1'b0));
    tv.push_back(mkv(DIV, 32'h7FFF0000, 32'h00008000, ov(32'hFFFE0000, 32'h7FFFFFFF), 1'b1, 1'b0));
    tv.push_back(mkv(MIN, 32'h00010000, 32'hFFFF0000, 32'hFFFF0000, 1'b0, 1'b0));
    tv.push_back(mkv(MAX, 32'h00010000, 32'hFFFF0000, 32'h00010000, 1'b0, 1'b0));
    tv.push_back(mkv(MIN, 32'h00000005, 32'h00000005, 32'h00000005, 1'b0, 1'b0));
    tv.push_back(mkv(ABS, 32'hFFFE8000, 32'h12345678, 32'h00018000, 1'b0, 1'b0));
    tv.push_back(mkv(ABS, 32'h80000000, 32'h00000000, ov(32'h80000000, 32'h7FFFFFFF), 1'b1, 1'b0));
    tv.push_back(mkv(NEG, 32'h00018000, 32'h00000000, 32'hFFFE8000, 1'b0, 1'b0));
    tv.push_back(mkv(NEG, 32'h80000000, 32'h00000000, ov(32'h80000000, 32'h7FFFFFFF), 1'b1, 1'b0));

    reset = 1'b1;
    bus.in_valid = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_value", bus.out_value, 32'h0);
    chk("rst_out_ovf", bus.out_ovf, 1'b0);
    chk("rst_out_dbz", bus.out_dbz, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    reset = 1'b0;

    bus.out_ready = 1'b1;
    send(MUL, 32'hFFFE8000, 32'h00020000, mk(32'hFFFD0000, 1'b0, 1'b0));
    chk("mul_latency_valid", bus.out_valid, 1'b1);
    step(acc);
    chk("mul_consumed", bus.out_valid, 1'b0);

    send(DIV, 32'h00010000, 32'h00030000, mk(32'h00005555, 1'b0, 1'b0));
    k = 0;
    rdy_hi = 1'b0;
    while (!bus.out_valid && k < 100) begin
      if (bus.in_ready) rdy_hi = 1'b1;
      step(acc);
      k++;
    end
    chk("div_latency", k, 48);
    chk("div_in_ready_calc", rdy_hi, 1'b0);
    step(acc);

    send(DIV, 32'hFFFF0000, 32'h00000000, mk(32'h7FFFFFFF, 1'b0, 1'b1));
    chk("dbz_latency_valid", bus.out_valid, 1'b1);
    chk("dbz_flag", bus.out_dbz, 1'b1);
    step(acc);

    foreach (tv[i]) send(tv[i].op, tv[i].a, tv[i].b, mk(tv[i].v, tv[i].ovf, tv[i].dbz));
    drain();

    bus.out_ready = 1'b0;
    send(ADD, 32'h00010000, 32'h00020000, mk(32'h00030000, 1'b0, 1'b0));
    bus.in_valid = 1'b1; bus.op = SUB; bus.a = 32'h00010000; bus.b = 32'h00030000;
    pend = mk(32'hFFFE0000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_in_ready", bus.in_ready, 1'b0);
      chk("bp_out_valid", bus.out_valid, 1'b1);
      chk("bp_out_value", bus.out_value, 32'h00030000);
      chk("bp_out_ovf", bus.out_ovf, 1'b0);
      @(posedge clk);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    step(acc);
    bus.in_valid = 1'b0;
    chk("bp_accept_same_edge", acc, 1'b1);
    chk("bp_next_valid", bus.out_valid, 1'b1);
    step(acc);

    send(DIV, 32'h00010000, 32'h00030000, mk(32'h00005555, 1'b0, 1'b0));
    repeat (19) step(acc);
    reset = 1'b1;
    step(acc);
    reset = 1'b0;
    sb_q.delete();
    chk("midcalc_rst_valid", bus.out_valid, 1'b0);
    chk("midcalc_rst_in_ready", bus.in_ready, 1'b1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid) seen++;
      step(acc);
    end
    chk("midcalc_rst_no_output", seen, 0);
    send(NEG, 32'h80000000, 32'h00000000, mk(ov(32'h80000000, 32'h7FFFFFFF), 1'b1, 1'b0));
    chk("neg_min_valid", bus.out_valid, 1'b1);
    drain();

    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      if (rop == DIV && $urandom_range(0, 2) != 0) rop = MUL;
      ra = 32'($signed($urandom) >>> $urandom_range(0, 16));
      rb = 32'($signed($urandom) >>> $urandom_range(0, 16));
      if ($urandom_range(0, 9) == 0) rb = '0;
      if ($urandom_range(0, 15) == 0) ra = 32'h80000000;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      send(rop, ra, rb, model(rop, ra, rb));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
